tl_mem_ul: RTL and testbench
============================

# tl_mem_ul

Parametrised TileLink-UL slave memory: the next generation of the single-beat-width `tl_mem` slave. Width, depth, source width and maximum burst size are configurable. It supports PutFullData, PutPartialData and Get with multi-beat bursts and byte-masked writes. Error responses (`denied`/`corrupt`) are produced for illegal requests. It sits behind the TileLink crossbar as the backing RAM for simulation and FPGA builds, serving one transaction at a time.

## Interface
Parameters:
- `DW`, 128: data-bus width in bits; power of two, ≥ 32.
- `AW`, 32: address width.
- `SW`, 3: source-ID width.
- `DEPTH`, 256: number of `DW`-bit words.
- `MAX_SIZE`, 6: largest legal `a_size` (log2 bytes).

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `tlslv_a_opcode/param/size/source/address/mask/data/corrupt/valid`  in  3/3/8/SW/AW/DW/8/DW/1/1: TL-A channel.
- `tlslv_a_ready`  out  1: A channel ready.
- `tlslv_d_opcode/param/size/source/sink/denied/data/corrupt/valid`  out  3/2/8/SW/3/1/DW/1/1: TL-D channel.
- `tlslv_d_ready`  in  1: D channel ready.

## Operation
- Definitions: `BB = DW/8` (bytes per beat). Beats per transaction = `max(1, 2^a_size / BB)`. Word index = `address[log2(BB) +: log2(DEPTH)]`; the index increments per beat, with no wrap.
- Legality: a request is legal iff the opcode ∈ {0, 1, 4}, `a_size ≤ MAX_SIZE`, `address` is aligned to `2^a_size`, and the last byte < `DEPTH*BB`. An illegal request sets `err`.
- State machine, states IDLE / WRITE / WACK / READ:
  - IDLE, A fire with opcode 0/1: the first beat is written and the beat counter is loaded. If single-beat, go to WACK; otherwise go to WRITE.
  - WRITE: each A fire writes one beat. The final beat moves to WACK. `opcode`, `size`, `source` and `address` are ignored on beats after the first.
  - WACK: `d_valid = 1`, `d_opcode = 0` (AccessAck). On D fire, return to IDLE.
  - IDLE, A fire with opcode 4: the RAM read of beat 0 is issued and the state moves to READ.
  - READ: `d_valid = 1`, `d_opcode = 1` (AccessAckData). Each D fire issues the next RAM read. The D fire on the last beat returns to IDLE.
- `a_ready` = 1 in IDLE and WRITE, 0 in WACK and READ.
- Write data: byte `i` is written iff `mask[i]`. For PutFullData the mask is forced to all-ones. When `err` is set, nothing is written.
- Read with `err`: every beat still issues, with `d_data = 0`, `d_corrupt = 1` and `d_denied = 1`.
- Response fields:
  - `d_size` and `d_source` are latched from the first A beat.
  - `d_param = 0`, `d_sink = 0`.
  - `d_denied = err`, held for the whole response.
- Reset mid-operation: the transaction is abandoned, the state returns to IDLE and outputs take their reset values. RAM contents are not cleared.

## Timing
- Reset values: `a_ready = 0`; `d_valid`, `d_denied` and `d_corrupt` = 0; `d_data`, `d_opcode`, `d_size` and `d_source` = 0. `a_ready` rises at the first rising edge after `rst` deasserts.
- Write: when the last A beat fires at edge N, `d_valid` is high from cycle N+1 until D fires. `a_ready` returns the cycle after the D fire.
- Read: when the Get fires at edge N, beat 0 is on D at N+1. With `d_ready` held at 1, one beat is delivered per cycle with no bubbles.
- Read back-pressure: with `d_ready = 0`, `d_data`, `d_valid` and the beat counter hold. The RAM output register is only updated on A fire or on a non-last D fire.
- A-channel gaps (`a_valid = 0`) during WRITE are allowed; the state waits indefinitely.
- Ordering: a write followed by a read of the same word returns the new data.

## Structure
- Shared package `tl_pkg`:
  - opcode constants `PUT_FULL = 0`, `PUT_PART = 1`, `GET = 4`, `ACK = 0`, `ACK_DATA = 1`;
  - FSM state encoding.
- Sub-module `tl_mem_ram`: single-port synchronous RAM, `DEPTH` × `DW`, with byte write-enables. Read data is registered, with a read-enable hold.
- The FSM, beat counter and legality check live in `tl_mem_ul`.

## Test plan
1. **Burst write:** Reset, then PutFullData at address 0x0, `size = 5`, beats `data = 1` then `2`. Expect one AccessAck with `d_size = 5` and `denied = 0`, and `a_ready = 0` while WACK is pending.
2. **Burst read:** Get at 0x0, `size = 5`, with `d_ready = 1`. Expect 2 beats on consecutive cycles, `d_data = 1` then `2`, and first `d_valid` one cycle after the A fire.
3. **Partial write:** PutPartialData at 0x10, `size = 4`, `mask = 0x000F`, `data = 0xAABBCCDD` (word previously `2`). A Get at 0x10 then returns `0x...AABBCCDD` with the upper bytes unchanged.
4. **Read back-pressure:** Get at 0x0, `size = 6` (4 beats), with `d_ready` toggling 1,0,0,1,… Expect the data to hold during stalls and the sequence to match the prior writes exactly.
5. **Illegal requests:**
   - Get at `DEPTH*BB`, `size = 4`: expect `d_denied = 1`, `d_corrupt = 1`, `d_data = 0`.
   - PutFullData with `size = 7`: expect `denied = 1` and memory unchanged.
6. **Reset mid-read:** Assert `rst = 0` in the middle of a 4-beat Get. Expect outputs to reach their reset values immediately. A subsequent Get returns the pre-reset RAM data.

Source files
------------

// File: rtl/tl_pkg.sv
`timescale 1ns/1ps
// Shared TileLink-UL definitions: A/D opcodes and the slave memory state encoding.
package tl_pkg;

  localparam logic [2:0] PUT_FULL = 3'd0;
  localparam logic [2:0] PUT_PART = 3'd1;
  localparam logic [2:0] GET      = 3'd4;
  localparam logic [2:0] ACK      = 3'd0;
  localparam logic [2:0] ACK_DATA = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WACK  = 2'd2,
    ST_READ  = 2'd3
  } state_e;

endpackage

// File: rtl/tl_mem_ram.sv
`timescale 1ns/1ps
// Single-port synchronous RAM, DEPTH x DW, byte write-enables and a registered
// read port that holds its value whenever no read is requested.
module tl_mem_ram #(
  parameter int DW    = 128,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_re,
  input  logic [DW/8-1:0]          i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [DW-1:0]            i_wdata,
  output logic [DW-1:0]            o_rdata
);

  localparam int BB = DW / 8;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // NOTE: the storage array has no reset; contents must survive a reset, and a
  // reset loop over every word would also stop it mapping onto block RAM.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BB; b++) begin
      if (i_we[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process ordering in simulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/tl_mem_ul.sv
`timescale 1ns/1ps
// TileLink-UL slave memory: PutFullData/PutPartialData/Get with multi-beat
// bursts, byte masks and denied/corrupt responses; one transaction at a time.
module tl_mem_ul
  import tl_pkg::*;
#(
  parameter int DW       = 128,
  parameter int AW       = 32,
  parameter int SW       = 3,
  parameter int DEPTH    = 256,
  parameter int MAX_SIZE = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      tlslv_a_opcode,
  input  logic [2:0]      tlslv_a_param,
  input  logic [7:0]      tlslv_a_size,
  input  logic [SW-1:0]   tlslv_a_source,
  input  logic [AW-1:0]   tlslv_a_address,
  input  logic [DW/8-1:0] tlslv_a_mask,
  input  logic [DW-1:0]   tlslv_a_data,
  input  logic            tlslv_a_corrupt,
  input  logic            tlslv_a_valid,
  output logic            tlslv_a_ready,
  output logic [2:0]      tlslv_d_opcode,
  output logic [1:0]      tlslv_d_param,
  output logic [7:0]      tlslv_d_size,
  output logic [SW-1:0]   tlslv_d_source,
  output logic [2:0]      tlslv_d_sink,
  output logic            tlslv_d_denied,
  output logic [DW-1:0]   tlslv_d_data,
  output logic            tlslv_d_corrupt,
  output logic            tlslv_d_valid,
  input  logic            tlslv_d_ready
);

  localparam int BB     = DW / 8;
  localparam int LOG_BB = $clog2(BB);
  localparam int IW     = $clog2(DEPTH);
  localparam int CW     = 16;
  localparam logic [AW:0] MEM_BYTES = (AW+1)'(DEPTH * BB);

  state_e          r_state, w_next;
  logic            r_a_ready;
  logic [IW-1:0]   r_idx;
  logic [CW-1:0]   r_left;
  logic            r_err;
  logic            r_full;
  logic [7:0]      r_size;
  logic [SW-1:0]   r_source;

  logic            w_a_fire, w_d_fire;
  logic [AW:0]     w_bytes, w_last;
  logic            w_legal;
  logic [IW-1:0]   w_idx;
  logic [CW-1:0]   w_beats;
  logic            w_ram_re;
  logic [BB-1:0]   w_ram_we;
  logic [IW-1:0]   w_ram_addr;
  logic [DW-1:0]   w_rdata;
  logic            w_unused;

  // Beats per transaction, saturating for absurd sizes so the counter never wraps.
  function automatic logic [CW-1:0] beats_of(input logic [7:0] size);
    logic [7:0] sh;
    if (size <= 8'(LOG_BB)) return CW'(1);
    sh = size - 8'(LOG_BB);
    if (sh >= 8'(CW)) return '1;
    return CW'(1) << sh;
  endfunction

  assign w_a_fire = tlslv_a_valid & r_a_ready;
  assign w_d_fire = tlslv_d_valid & tlslv_d_ready;
  assign w_idx    = tlslv_a_address[LOG_BB +: IW];
  assign w_beats  = beats_of(tlslv_a_size);
  assign w_unused = ^{tlslv_a_param, tlslv_a_corrupt};

  // Legality of the first A beat; the size guard keeps the shift in range.
  always_comb begin
    w_bytes = (AW+1)'(1) << tlslv_a_size;
    w_last  = {1'b0, tlslv_a_address} + w_bytes - (AW+1)'(1);
    w_legal = ((tlslv_a_opcode == PUT_FULL) || (tlslv_a_opcode == PUT_PART) ||
               (tlslv_a_opcode == GET))
              && (tlslv_a_size <= 8'(MAX_SIZE))
              && (({1'b0, tlslv_a_address} & (w_bytes - (AW+1)'(1))) == '0)
              && (w_last < MEM_BYTES);
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    w_next     = r_state;
    w_ram_re   = 1'b0;
    w_ram_we   = '0;
    w_ram_addr = r_idx;
    unique case (r_state)
      ST_IDLE: begin
        if (w_a_fire) begin
          w_ram_addr = w_idx;
          if (tlslv_a_opcode == GET) begin
            w_ram_re = 1'b1;
            w_next   = ST_READ;
          end else begin
            // Any non-Get opcode takes the write path; illegal ones only ack.
            if (w_legal) w_ram_we = (tlslv_a_opcode == PUT_FULL) ? '1 : tlslv_a_mask;
            w_next = (w_beats == CW'(1)) ? ST_WACK : ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (w_a_fire) begin
          if (!r_err) w_ram_we = r_full ? '1 : tlslv_a_mask;
          if (r_left == CW'(1)) w_next = ST_WACK;
        end
      end
      ST_WACK: begin
        if (w_d_fire) w_next = ST_IDLE;
      end
      ST_READ: begin
        if (w_d_fire) begin
          if (r_left == '0) w_next = ST_IDLE;
          else              w_ram_re = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_a_ready <= 1'b0;
      r_idx     <= '0;
      r_left    <= '0;
      r_err     <= 1'b0;
      r_full    <= 1'b0;
      r_size    <= '0;
      r_source  <= '0;
    end else begin
      r_state   <= w_next;
      r_a_ready <= (w_next == ST_IDLE) || (w_next == ST_WRITE);
      if (r_state == ST_IDLE && w_a_fire) begin
        r_idx    <= w_idx + IW'(1);
        r_left   <= w_beats - CW'(1);
        r_err    <= ~w_legal;
        r_full   <= (tlslv_a_opcode == PUT_FULL);
        r_size   <= tlslv_a_size;
        r_source <= tlslv_a_source;
      end else if ((r_state == ST_WRITE && w_a_fire) ||
                   (r_state == ST_READ && w_d_fire && r_left != '0)) begin
        r_idx  <= r_idx + IW'(1);
        r_left <= r_left - CW'(1);
      end
    end
  end

  tl_mem_ram #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_re    (w_ram_re),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (tlslv_a_data),
    .o_rdata (w_rdata)
  );

  assign tlslv_a_ready   = r_a_ready;
  assign tlslv_d_valid   = (r_state == ST_WACK) || (r_state == ST_READ);
  assign tlslv_d_opcode  = (r_state == ST_READ) ? ACK_DATA : ACK;
  assign tlslv_d_param   = '0;
  assign tlslv_d_sink    = '0;
  assign tlslv_d_size    = r_size;
  assign tlslv_d_source  = r_source;
  assign tlslv_d_denied  = r_err & tlslv_d_valid;
  assign tlslv_d_corrupt = r_err & (r_state == ST_READ);
  assign tlslv_d_data    = r_err ? '0 : w_rdata;

endmodule

// File: tb/tb_tl_mem_ul.sv
`timescale 1ns/1ps
// Self-checking bench for tl_mem_ul: a byte-level memory model feeds a queue of
// expected D beats that is drained as the DUT responds.
module tb_tl_mem_ul;
  import tl_pkg::*;

  localparam int DW       = 128;
  localparam int AW       = 32;
  localparam int SW       = 3;
  localparam int DEPTH    = 256;
  localparam int MAX_SIZE = 6;
  localparam int BB       = DW / 8;
  localparam int LOG_BB   = $clog2(BB);

  typedef struct {
    logic [2:0]    op;
    logic [7:0]    sz;
    logic [SW-1:0] src;
    logic          den;
    logic          cor;
    logic [DW-1:0] data;
  } d_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0]    tlslv_a_opcode = '0;
  logic [2:0]    tlslv_a_param = '0;
  logic [7:0]    tlslv_a_size = '0;
  logic [SW-1:0] tlslv_a_source = '0;
  logic [AW-1:0] tlslv_a_address = '0;
  logic [BB-1:0] tlslv_a_mask = '0;
  logic [DW-1:0] tlslv_a_data = '0;
  logic          tlslv_a_corrupt = 1'b0;
  logic          tlslv_a_valid = 1'b0;
  logic          tlslv_a_ready;
  logic [2:0]    tlslv_d_opcode;
  logic [1:0]    tlslv_d_param;
  logic [7:0]    tlslv_d_size;
  logic [SW-1:0] tlslv_d_source;
  logic [2:0]    tlslv_d_sink;
  logic          tlslv_d_denied;
  logic [DW-1:0] tlslv_d_data;
  logic          tlslv_d_corrupt;
  logic          tlslv_d_valid;
  logic          tlslv_d_ready = 1'b0;

  d_exp_t        exp_q[$];
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] wbuf [8];
  int            n_checks = 0;
  int            n_errors = 0;

  always #5 clk = ~clk;

  tl_mem_ul #(
    .DW(DW), .AW(AW), .SW(SW), .DEPTH(DEPTH), .MAX_SIZE(MAX_SIZE)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .tlslv_a_opcode  (tlslv_a_opcode),
    .tlslv_a_param   (tlslv_a_param),
    .tlslv_a_size    (tlslv_a_size),
    .tlslv_a_source  (tlslv_a_source),
    .tlslv_a_address (tlslv_a_address),
    .tlslv_a_mask    (tlslv_a_mask),
    .tlslv_a_data    (tlslv_a_data),
    .tlslv_a_corrupt (tlslv_a_corrupt),
    .tlslv_a_valid   (tlslv_a_valid),
    .tlslv_a_ready   (tlslv_a_ready),
    .tlslv_d_opcode  (tlslv_d_opcode),
    .tlslv_d_param   (tlslv_d_param),
    .tlslv_d_size    (tlslv_d_size),
    .tlslv_d_source  (tlslv_d_source),
    .tlslv_d_sink    (tlslv_d_sink),
    .tlslv_d_denied  (tlslv_d_denied),
    .tlslv_d_data    (tlslv_d_data),
    .tlslv_d_corrupt (tlslv_d_corrupt),
    .tlslv_d_valid   (tlslv_d_valid),
    .tlslv_d_ready   (tlslv_d_ready)
  );

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic bit legal_req(input logic [2:0] op, input logic [7:0] size,
                                   input logic [AW-1:0] addr);
    longint bytes;
    longint a;
    if (op != PUT_FULL && op != PUT_PART && op != GET) return 1'b0;
    if (size > 8'(MAX_SIZE)) return 1'b0;
    bytes = longint'(1) << size;
    a     = longint'(addr);
    if ((a % bytes) != 0) return 1'b0;
    return (a + bytes) <= longint'(DEPTH * BB);
  endfunction

  function automatic int n_beats(input logic [7:0] size);
    if (size <= 8'(LOG_BB)) return 1;
    return (1 << size) / BB;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_ready"},   tlslv_a_ready,   '0);
    check({tag, "_d_valid"},   tlslv_d_valid,   '0);
    check({tag, "_d_denied"},  tlslv_d_denied,  '0);
    check({tag, "_d_corrupt"}, tlslv_d_corrupt, '0);
    check({tag, "_d_data"},    tlslv_d_data,    '0);
    check({tag, "_d_opcode"},  tlslv_d_opcode,  '0);
    check({tag, "_d_size"},    tlslv_d_size,    '0);
    check({tag, "_d_source"},  tlslv_d_source,  '0);
  endtask

  // Called at a falling edge; returns at the falling edge after the beat fired.
  task automatic send_beat(input logic [2:0] op, input logic [7:0] size,
                           input logic [SW-1:0] src, input logic [AW-1:0] addr,
                           input logic [BB-1:0] mask, input logic [DW-1:0] data);
    int waited = 0;
    tlslv_a_opcode  = op;
    tlslv_a_size    = size;
    tlslv_a_source  = src;
    tlslv_a_address = addr;
    tlslv_a_mask    = mask;
    tlslv_a_data    = data;
    tlslv_a_valid   = 1'b1;
    #1;
    while (!tlslv_a_ready && waited < 50) begin
      @(negedge clk); #1;
      waited++;
    end
    check("a_ready_wait", tlslv_a_ready, 1);
    @(negedge clk);
    tlslv_a_valid = 1'b0;
  endtask

  // Drains n D beats with d_ready following pat[cyc % len]; done means the
  // response is expected to be complete so a_ready must come back.
  task automatic receive_d(input int n, input logic [7:0] pat, input int len, input bit done);
    int            got = 0;
    int            cyc = 0;
    bit            stalled = 1'b0;
    logic [DW-1:0] held = '0;
    d_exp_t        e;
    while (got < n && cyc < 200) begin
      tlslv_d_ready = pat[cyc % len];
      #1;
      check("d_valid", tlslv_d_valid, 1);
      check("a_ready_busy", tlslv_a_ready, 0);
      if (stalled) check("d_data_hold", tlslv_d_data, held);
      if (tlslv_d_valid && tlslv_d_ready) begin
        if (exp_q.size() == 0) begin
          check("d_unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("d_opcode",  tlslv_d_opcode,  e.op);
          check("d_size",    tlslv_d_size,    e.sz);
          check("d_source",  tlslv_d_source,  e.src);
          check("d_denied",  tlslv_d_denied,  e.den);
          check("d_corrupt", tlslv_d_corrupt, e.cor);
          check("d_param",   tlslv_d_param,   0);
          check("d_sink",    tlslv_d_sink,    0);
          if (e.op == ACK_DATA) check("d_data", tlslv_d_data, e.data);
        end
        stalled = 1'b0;
        got++;
      end else begin
        held    = tlslv_d_data;
        stalled = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    tlslv_d_ready = 1'b0;
    check("d_beat_count", got, n);
    if (done) begin
      #1;
      check("a_ready_after_d", tlslv_a_ready, 1);
    end
  endtask

  task automatic put(input logic [2:0] op, input logic [7:0] size, input logic [SW-1:0] src,
                     input logic [AW-1:0] addr, input logic [BB-1:0] mask, input bit gap);
    bit     ok = legal_req(op, size, addr);
    int     nb = n_beats(size);
    int     base = int'(addr / BB);
    d_exp_t e;
    e.op = ACK; e.sz = size; e.src = src; e.den = ~ok; e.cor = 1'b0; e.data = '0;
    exp_q.push_back(e);
    for (int b = 0; b < nb; b++) begin
      // Later beats carry junk header fields, which the slave must ignore.
      send_beat((b == 0) ? op : GET, (b == 0) ? size : 8'hFF, src, addr, mask, wbuf[b]);
      if (ok) begin
        for (int i = 0; i < BB; i++)
          if (op == PUT_FULL || mask[i]) model[base + b][i*8 +: 8] = wbuf[b][i*8 +: 8];
      end
      if (gap && b < nb - 1) @(negedge clk);
    end
    #1;
    check("wack_d_valid", tlslv_d_valid, 1);
    check("wack_a_ready", tlslv_a_ready, 0);
    receive_d(1, 8'b10, 2, 1'b1);
  endtask

  task automatic start_get(input logic [7:0] size, input logic [SW-1:0] src,
                           input logic [AW-1:0] addr, output int nb);
    bit     ok = legal_req(GET, size, addr);
    int     base = int'(addr / BB);
    d_exp_t e;
    nb = n_beats(size);
    for (int b = 0; b < nb; b++) begin
      e.op = ACK_DATA; e.sz = size; e.src = src; e.den = ~ok; e.cor = ~ok;
      e.data = ok ? model[base + b] : '0;
      exp_q.push_back(e);
    end
    send_beat(GET, size, src, addr, '1, '0);
    #1;
    check("get_first_valid", tlslv_d_valid, 1);
  endtask

  task automatic get(input logic [7:0] size, input logic [SW-1:0] src,
                     input logic [AW-1:0] addr, input logic [7:0] pat, input int len);
    int nb;
    start_get(size, src, addr, nb);
    receive_d(nb, pat, len, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b1;
    #1;
    check("a_ready_before_edge", tlslv_a_ready, 0);
    @(negedge clk); #1;
    check("a_ready_after_rst", tlslv_a_ready, 1);
    @(negedge clk);

    // Two-beat PutFullData then read it back with no back-pressure.
    wbuf[0] = 128'd1;
    wbuf[1] = 128'd2;
    put(PUT_FULL, 8'd5, 3'd1, 32'h0, '1, 1'b0);
    get(8'd5, 3'd2, 32'h0, 8'h01, 1);

    // Fill words 2..3 with an idle A cycle between beats.
    wbuf[0] = {$urandom, $urandom, $urandom, $urandom};
    wbuf[1] = {$urandom, $urandom, $urandom, $urandom};
    put(PUT_FULL, 8'd5, 3'd3, 32'h20, '1, 1'b1);

    // Partial write: only the low four bytes land, junk above them is masked off.
    wbuf[0] = {96'hFFFF_FFFF_1234_5678_9ABC_DEF0, 32'hAABB_CCDD};
    put(PUT_PART, 8'd4, 3'd4, 32'h10, 16'h000F, 1'b0);
    get(8'd4, 3'd5, 32'h10, 8'h01, 1);

    // Four-beat read under 1,0,0,1 back-pressure.
    get(8'd6, 3'd6, 32'h0, 8'b1001, 4);

    // Highest legal word.
    wbuf[0] = {$urandom, $urandom, $urandom, $urandom};
    put(PUT_FULL, 8'd4, 3'd7, 32'hFF0, '1, 1'b0);
    get(8'd4, 3'd0, 32'hFF0, 8'h01, 1);

    // Illegal: past the end, and misaligned.
    get(8'd4, 3'd1, 32'h1000, 8'h01, 1);
    get(8'd5, 3'd2, 32'h10, 8'b01, 2);

    // Illegal size: eight beats accepted, acked denied, memory untouched.
    for (int b = 0; b < 8; b++) wbuf[b] = {4{32'hDEAD_BEEF}};
    put(PUT_FULL, 8'd7, 3'd3, 32'h0, '1, 1'b0);
    get(8'd6, 3'd4, 32'h0, 8'h01, 1);

    // Reset in the middle of a four-beat read.
    start_get(8'd6, 3'd5, 32'h0, nb);
    receive_d(2, 8'h01, 1, 1'b0);
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("a_ready_before_edge2", tlslv_a_ready, 0);
    @(negedge clk);
    get(8'd6, 3'd6, 32'h0, 8'h01, 1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
